// File: rtl/stream_pkg.sv
// Shared stream-chain definitions: bus geometry, record delimiter, packer states.
// No logic, so no latency.
// No flow control of its own.
package stream_pkg;

    localparam int DATA_BUS_WIDTH_BYTES   = 8;
    localparam int MAX_UNCOMPRESSED_BYTES = 34;

    typedef logic [7:0] byte_t;

    // Separates the variable field from the fixed field inside a record.
    localparam byte_t VARIABLEFIELD_DELIMITER = 8'h2c;

    typedef enum logic [1:0] {
        PK_ACCEPT = 2'd0,
        PK_DRAIN  = 2'd1,
        PK_FLUSH  = 2'd2
    } packer_state_t;

endpackage

// File: rtl/byte_append_shifter.sv
// Places a record at byte offset fill into a copy of the packing buffer; also gives the buffer shifted down one bus word.
// Purely combinational, zero latency.
// No flow control; the caller decides which result to keep.
module byte_append_shifter
    import stream_pkg::*;
#(
    parameter int W         = DATA_BUS_WIDTH_BYTES,
    parameter int MAX_REC   = MAX_UNCOMPRESSED_BYTES,
    parameter int BUF_BYTES = MAX_REC + W - 1,
    parameter int FILL_W    = $clog2(BUF_BYTES + 1)
) (
    input  logic [BUF_BYTES-1:0][7:0] buffer_cur,
    input  logic [FILL_W-1:0]         fill,
    input  logic [MAX_REC-1:0][7:0]   record,
    input  logic [FILL_W-1:0]         len,
    output logic [BUF_BYTES-1:0][7:0] appended,
    output logic [BUF_BYTES-1:0][7:0] shifted
);

    localparam int BUF_BITS = BUF_BYTES * 8;
    localparam int REC_BITS = MAX_REC * 8;

    logic [REC_BITS-1:0] rec_mask;
    logic [BUF_BITS-1:0] rec_ext;
    logic [BUF_BITS-1:0] keep_mask;

    // Keep the bytes already held, zero the unused record tail, and drop the record in just above them.
    always_comb begin
        rec_mask  = ~({REC_BITS{1'b1}} << {len, 3'b000});
        rec_ext   = {{(BUF_BITS - REC_BITS){1'b0}}, record & rec_mask};
        keep_mask = ~({BUF_BITS{1'b1}} << {fill, 3'b000});
        appended  = (buffer_cur & keep_mask) | (rec_ext << {fill, 3'b000});
        shifted   = buffer_cur >> (W * 8);
    end

endmodule

// File: rtl/stream_record_packer.sv
// Packs variable-length records back-to-back onto a W-byte word bus; flush emits the trailing partial word.
// Record accept is zero-cycle; the first word appears the cycle after the take that completes it.
// Output words hold stable while dataOutReady is low; no record is taken while a word is pending or a flush is outstanding.
module stream_record_packer
    import stream_pkg::*;
#(
    parameter int    DATA_BUS_WIDTH_BYTES = stream_pkg::DATA_BUS_WIDTH_BYTES,
    parameter int    MAX_RECORD_BYTES     = stream_pkg::MAX_UNCOMPRESSED_BYTES,
    parameter byte_t FILL_BYTE            = 8'h00
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [MAX_RECORD_BYTES-1:0][7:0]        recordIn,
    input  logic [$clog2(MAX_RECORD_BYTES)-1:0]     recordByteLength,
    input  logic                                    recordValid,
    output logic                                    recordTaken,
    input  logic                                    flush,
    output logic [DATA_BUS_WIDTH_BYTES-1:0][7:0]    dataOut,
    output logic                                    dataOutValid,
    input  logic                                    dataOutReady,
    output logic [$clog2(DATA_BUS_WIDTH_BYTES):0]   dataOutByteCount,
    output logic                                    dataOutLast
);

    localparam int W         = DATA_BUS_WIDTH_BYTES;
    localparam int BUF_BYTES = MAX_RECORD_BYTES + W - 1;
    localparam int FILL_W    = $clog2(BUF_BYTES + 1);
    localparam int CNT_W     = $clog2(W) + 1;
    localparam logic [FILL_W-1:0] W_FILL   = FILL_W'(W);
    localparam logic [FILL_W-1:0] MAX_FILL = FILL_W'(MAX_RECORD_BYTES);

    packer_state_t             state_q, state_d;
    logic [FILL_W-1:0]         fill_q, fill_d;
    logic [FILL_W-1:0]         len_ext, len_clamped;
    logic                      pend_q, pend_d;
    logic [BUF_BYTES-1:0][7:0] buf_q, buf_d, buf_appended, buf_shifted;
    logic                      handshake, hold;
    logic                      out_vld_d, out_last_d;
    logic [CNT_W-1:0]          out_cnt_d;
    logic [W-1:0][7:0]         out_dat_d;

    assign len_ext     = FILL_W'(recordByteLength);
    assign len_clamped = (len_ext > MAX_FILL) ? MAX_FILL : len_ext;
    assign handshake   = dataOutValid && dataOutReady;
    assign hold        = dataOutValid && !dataOutReady;
    assign recordTaken = !reset && recordValid && (state_q == PK_ACCEPT) && !pend_q;

    byte_append_shifter #(
        .W         (W),
        .MAX_REC   (MAX_RECORD_BYTES),
        .BUF_BYTES (BUF_BYTES),
        .FILL_W    (FILL_W)
    ) u_shifter (
        .buffer_cur (buf_q),
        .fill       (fill_q),
        .record     (recordIn),
        .len        (len_clamped),
        .appended   (buf_appended),
        .shifted    (buf_shifted)
    );

    // Next state: append in ACCEPT, retire full words in DRAIN, retire the partial word in FLUSH.
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        buf_d   = buf_q;
        pend_d  = pend_q | flush;
        unique case (state_q)
            PK_ACCEPT: begin
                if (recordTaken) begin
                    buf_d  = buf_appended;
                    fill_d = fill_q + len_clamped;
                end
                if (fill_d >= W_FILL) begin
                    state_d = PK_DRAIN;
                end else if (pend_d) begin
                    state_d = PK_FLUSH;
                end
            end
            PK_DRAIN: begin
                if (handshake) begin
                    buf_d  = buf_shifted;
                    fill_d = fill_q - W_FILL;
                end
                if (fill_d < W_FILL) begin
                    state_d = pend_d ? PK_FLUSH : PK_ACCEPT;
                end
            end
            PK_FLUSH: begin
                // An empty buffer has nothing to emit, so the flush completes at once.
                if (fill_q == '0 || handshake) begin
                    fill_d  = '0;
                    pend_d  = 1'b0;
                    state_d = PK_ACCEPT;
                end
            end
            default: begin
                fill_d  = '0;
                pend_d  = 1'b0;
                state_d = PK_ACCEPT;
            end
        endcase
    end

    // Word to present next, derived from the next buffer so outputs can be registered without a bubble.
    always_comb begin
        out_vld_d  = (state_d == PK_DRAIN) || (state_d == PK_FLUSH && fill_d != '0);
        out_cnt_d  = '0;
        out_last_d = 1'b0;
        if (state_d == PK_DRAIN) begin
            out_cnt_d  = CNT_W'(W);
            out_last_d = pend_d && (fill_d == W_FILL);
        end else if (out_vld_d) begin
            out_cnt_d  = CNT_W'(fill_d);
            out_last_d = 1'b1;
        end
        for (int i = 0; i < W; i++) begin
            out_dat_d[i] = (i < int'(out_cnt_d)) ? buf_d[i] : FILL_BYTE;
        end
    end

    // Control state; reset drops buffered bytes and any outstanding flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= PK_ACCEPT;
            fill_q  <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            pend_q  <= pend_d;
        end
    end

    // Packing buffer contents; meaningless above fill_q, so never reset.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    // Output word register, frozen while a presented word waits for ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            dataOutValid     <= 1'b0;
            dataOutByteCount <= '0;
            dataOutLast      <= 1'b0;
            dataOut          <= {W{FILL_BYTE}};
        end else if (!hold) begin
            dataOutValid     <= out_vld_d;
            dataOutByteCount <= out_cnt_d;
            dataOutLast      <= out_last_d;
            dataOut          <= out_dat_d;
        end
    end

endmodule

// File: tb/tb_stream_record_packer.sv
// Bench for stream_record_packer: directed vector table, hand-written corner sequences, randomized traffic against a byte-queue model.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
// dataOutReady is randomized in the random phase to exercise hold behaviour.
module tb_stream_record_packer;

    localparam int W    = 8;
    localparam int MAXR = 34;
    localparam int LW   = $clog2(MAXR);
    localparam int CW   = $clog2(W) + 1;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [MAXR-1:0][7:0]  recordIn;
    logic [LW-1:0]         recordByteLength;
    logic                  recordValid;
    logic                  recordTaken;
    logic                  flush;
    logic [W-1:0][7:0]     dataOut;
    logic                  dataOutValid;
    logic                  dataOutReady;
    logic [CW-1:0]         dataOutByteCount;
    logic                  dataOutLast;

    int errors = 0;
    int checks = 0;

    bit rnd    = 1'b0;
    bit mon_en = 1'b0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    stream_record_packer dut (
        .clk              (clk),
        .reset            (reset),
        .recordIn         (recordIn),
        .recordByteLength (recordByteLength),
        .recordValid      (recordValid),
        .recordTaken      (recordTaken),
        .flush            (flush),
        .dataOut          (dataOut),
        .dataOutValid     (dataOutValid),
        .dataOutReady     (dataOutReady),
        .dataOutByteCount (dataOutByteCount),
        .dataOutLast      (dataOutLast)
    );

    typedef struct {
        int          rv;
        int          len;
        int          first;
        int          fl;
        int          t;
        int          v;
        int          c;
        logic [63:0] d;
        int          l;
    } vec_t;

    vec_t tbl[15];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_rec(input int first, input int len);
        for (int i = 0; i < MAXR; i++) recordIn[i] = 8'(first + i);
        recordByteLength = LW'(len);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        recordValid = 1'b0;
        flush = 1'b0;
        recordIn = '0;
        recordByteLength = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    // Presents the current recordIn until taken; the model queue receives its bytes at the take.
    task automatic send_rec(input int len);
        bit got;
        int nb;
        got = 1'b0;
        nb = (len > MAXR) ? MAXR : len;
        recordByteLength = LW'(len);
        recordValid = 1'b1;
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge clk);
            if (recordTaken) begin
                got = 1'b1;
                for (int i = 0; i < nb; i++) exp_q.push_back(recordIn[i]);
            end
            tick();
        end
        recordValid = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL send_timeout: got taken=0 expected taken=1 within 400 cycles");
        end
    endtask

    // Random downstream readiness.
    always @(posedge clk) begin
        if (rnd) begin
            #1;
            dataOutReady = ($urandom_range(0, 3) != 0);
        end
    end

    logic [63:0]   held_dat;
    logic [CW-1:0] held_cnt;
    logic          held_last;
    bit            held = 1'b0;
    int            mcnt;
    bit            mbad;
    logic [63:0]   mexp;

    // Stream monitor: every accepted word must carry the next bytes of the model queue.
    always @(negedge clk) begin
        if (mon_en) begin
            if (held) begin
                checks++;
                if (!dataOutValid || dataOut !== held_dat || dataOutByteCount !== held_cnt || dataOutLast !== held_last) begin
                    errors++;
                    $display("FAIL hold_stable: got vld=%0b dat=%h cnt=%0d last=%0b expected vld=1 dat=%h cnt=%0d last=%0b",
                             dataOutValid, dataOut, dataOutByteCount, dataOutLast, held_dat, held_cnt, held_last);
                end
            end
            held      = dataOutValid && !dataOutReady;
            held_dat  = dataOut;
            held_cnt  = dataOutByteCount;
            held_last = dataOutLast;
            if (recordTaken) begin
                checks++;
                if (dataOutValid) begin
                    errors++;
                    $display("FAIL take_overlap: got valid=1 with take expected valid=0");
                end
            end
            if (dataOutValid && dataOutReady) begin
                checks++;
                mbad = 1'b0;
                mexp = '0;
                mcnt = int'(dataOutByteCount);
                if (mcnt < 1 || mcnt > W) mbad = 1'b1;
                for (int j = 0; j < W; j++) begin
                    if (j < mcnt) begin
                        if (exp_q.size() == 0) mbad = 1'b1;
                        else mexp[8*j +: 8] = exp_q.pop_front();
                    end
                    if (dataOut[j] !== mexp[8*j +: 8]) mbad = 1'b1;
                end
                if (mcnt < W && !dataOutLast) mbad = 1'b1;
                if (dataOutLast && exp_q.size() != 0) mbad = 1'b1;
                if (mbad) begin
                    errors++;
                    $display("FAIL word: got dat=%h cnt=%0d last=%0b expected dat=%h remaining=%0d",
                             dataOut, dataOutByteCount, dataOutLast, mexp, exp_q.size());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] e;
        int len;

        //            rv len first fl  t  v  c  data                     l
        tbl[0]  = '{1,  5, 'h01, 0, 1, 0, 0, 64'h0,                   0};
        tbl[1]  = '{1,  5, 'h11, 0, 1, 0, 0, 64'h0,                   0};
        tbl[2]  = '{0,  0, 'h00, 0, 0, 1, 8, 64'h1312110504030201,    0};
        tbl[3]  = '{1,  1, 'hCC, 1, 1, 0, 0, 64'h0,                   0};
        tbl[4]  = '{1,  2, 'h30, 0, 0, 1, 3, 64'h0000000000CC1514,    1};
        tbl[5]  = '{1,  2, 'h30, 0, 1, 0, 0, 64'h0,                   0};
        tbl[6]  = '{0,  0, 'h00, 1, 0, 0, 0, 64'h0,                   0};
        tbl[7]  = '{0,  0, 'h00, 0, 0, 1, 2, 64'h0000000000003130,    1};
        tbl[8]  = '{1,  0, 'h77, 0, 1, 0, 0, 64'h0,                   0};
        tbl[9]  = '{0,  0, 'h00, 1, 0, 0, 0, 64'h0,                   0};
        tbl[10] = '{0,  0, 'h00, 0, 0, 0, 0, 64'h0,                   0};
        tbl[11] = '{1,  3, 'h40, 0, 1, 0, 0, 64'h0,                   0};
        tbl[12] = '{1, 40, 'h50, 0, 1, 0, 0, 64'h0,                   0};
        tbl[13] = '{0,  0, 'h00, 0, 0, 1, 8, 64'h5453525150424140,    0};
        tbl[14] = '{0,  0, 'h00, 0, 0, 1, 8, 64'h5C5B5A5958575655,    0};

        // Reset state, with a record offered during reset.
        reset = 1'b1;
        flush = 1'b0;
        dataOutReady = 1'b1;
        fill_rec('h01, 5);
        recordValid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_taken", 64'(recordTaken), 64'd0);
        check("rst_valid", 64'(dataOutValid), 64'd0);
        check("rst_count", 64'(dataOutByteCount), 64'd0);
        check("rst_last",  64'(dataOutLast), 64'd0);
        check("rst_data",  64'(dataOut), 64'd0);
        tick();
        reset = 1'b0;
        recordValid = 1'b0;

        // Directed per-cycle vectors with dataOutReady high.
        for (int k = 0; k < 15; k++) begin
            fill_rec(tbl[k].first, tbl[k].len);
            recordValid = 1'(tbl[k].rv);
            flush = 1'(tbl[k].fl);
            @(negedge clk);
            check($sformatf("tbl_taken[%0d]", k), 64'(recordTaken), 64'(tbl[k].t));
            check($sformatf("tbl_valid[%0d]", k), 64'(dataOutValid), 64'(tbl[k].v));
            check($sformatf("tbl_count[%0d]", k), 64'(dataOutByteCount), 64'(tbl[k].c));
            check($sformatf("tbl_data[%0d]", k),  64'(dataOut), tbl[k].d);
            check($sformatf("tbl_last[%0d]", k),  64'(dataOutLast), 64'(tbl[k].l));
            tick();
        end
        recordValid = 1'b0;
        flush = 1'b0;

        // 34-byte record from empty: four consecutive words, no takes meanwhile, then a 5-cycle stall.
        do_reset();
        dataOutReady = 1'b1;
        fill_rec('h00, 34);
        recordValid = 1'b1;
        @(negedge clk);
        check("big_take", 64'(recordTaken), 64'd1);
        tick();
        fill_rec('hA0, 8);
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < W; j++) e[8*j +: 8] = 8'(8*k + j);
            @(negedge clk);
            check($sformatf("big_valid[%0d]", k), 64'(dataOutValid), 64'd1);
            check($sformatf("big_data[%0d]", k), 64'(dataOut), e);
            check($sformatf("big_notake[%0d]", k), 64'(recordTaken), 64'd0);
            tick();
        end
        @(negedge clk);
        check("big_take2", 64'(recordTaken), 64'd1);
        check("big_idle", 64'(dataOutValid), 64'd0);
        tick();
        fill_rec('h77, 1);
        dataOutReady = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("stall_valid[%0d]", k), 64'(dataOutValid), 64'd1);
            check($sformatf("stall_data[%0d]", k), 64'(dataOut), 64'hA5A4A3A2A1A02120);
            check($sformatf("stall_count[%0d]", k), 64'(dataOutByteCount), 64'd8);
            check($sformatf("stall_notake[%0d]", k), 64'(recordTaken), 64'd0);
            tick();
        end
        dataOutReady = 1'b1;
        @(negedge clk);
        check("stall_release_valid", 64'(dataOutValid), 64'd1);
        tick();
        @(negedge clk);
        check("stall_retired", 64'(dataOutValid), 64'd0);
        check("stall_then_take", 64'(recordTaken), 64'd1);
        tick();
        recordValid = 1'b0;

        // Reset in the middle of draining a 34-byte record.
        do_reset();
        dataOutReady = 1'b1;
        fill_rec('h00, 34);
        recordValid = 1'b1;
        @(negedge clk);
        tick();
        recordValid = 1'b0;
        @(negedge clk);
        check("mid_word0", 64'(dataOut), 64'h0706050403020100);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        fill_rec('h60, 8);
        recordValid = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", 64'(dataOutValid), 64'd0);
        check("mid_rst_take", 64'(recordTaken), 64'd1);
        tick();
        recordValid = 1'b0;
        @(negedge clk);
        check("mid_one_valid", 64'(dataOutValid), 64'd1);
        check("mid_one_data", 64'(dataOut), 64'h6766656463626160);
        check("mid_one_count", 64'(dataOutByteCount), 64'd8);
        tick();
        @(negedge clk);
        check("mid_only_one", 64'(dataOutValid), 64'd0);
        tick();

        // Randomized traffic against the byte-queue model.
        do_reset();
        exp_q.delete();
        rnd = 1'b1;
        mon_en = 1'b1;
        for (int n = 0; n < 200; n++) begin
            len = $urandom_range(0, 36);
            if ($urandom_range(0, 9) == 0) len = 0;
            for (int i = 0; i < MAXR; i++) recordIn[i] = 8'($urandom);
            send_rec(len);
            repeat ($urandom_range(0, 2)) tick();
            if ($urandom_range(0, 7) == 0) pulse_flush();
        end
        pulse_flush();
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !dataOutValid) break;
        end
        check("rand_drained", 64'(exp_q.size()), 64'd0);
        check("rand_idle", 64'(dataOutValid), 64'd0);
        mon_en = 1'b0;
        rnd = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_record_packer.md
# stream_record_packer

Transmit-side counterpart of the stream element chain. Accepts whole variable-length records (variable field, 0x2c delimiter, fixed field), each presented as a byte array plus a byte length. Packs them back-to-back with no gaps onto a DATA_BUS_WIDTH_BYTES-wide data bus, so a record may begin at any byte lane and straddle words. It sits between the record store/decompressor and the outgoing AXI-stream word interface; an explicit flush emits the trailing partial word.

## Interface
Parameters:
- DATA_BUS_WIDTH_BYTES, 8, output bus width in bytes; power of 2.
- MAX_RECORD_BYTES, 34, largest record accepted.
- FILL_BYTE, 8'h00, value driven on unused lanes of a partial word.

Ports:
- clk  in  1  sole clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- recordIn  in  [MAX_RECORD_BYTES-1:0][7:0]  record bytes; byte 0 first on the wire.
- recordByteLength  in  $clog2(MAX_RECORD_BYTES)  valid bytes in recordIn.
- recordValid  in  1  record presented; held stable until taken.
- recordTaken  out  1  combinational; record consumed on an edge where recordValid && recordTaken.
- flush  in  1  single-cycle request to drain all buffered bytes.
- dataOut  out  [DATA_BUS_WIDTH_BYTES-1:0][7:0]  packed word; lane 0 first.
- dataOutValid  out  1  word valid.
- dataOutReady  in  1  downstream accept.
- dataOutByteCount  out  $clog2(DATA_BUS_WIDTH_BYTES)+1  valid lanes, 1..W.
- dataOutLast  out  1  final word of a flush.

## Operation
- Packing buffer: MAX_RECORD_BYTES+DATA_BUS_WIDTH_BYTES-1 bytes (41 at defaults). fillCount gives bytes held, 0..41. Byte 0 is the oldest.
- State register, encoded 2 bits:
  - ACCEPT: fillCount<W and no flush pending.
  - DRAIN: fillCount>=W.
  - FLUSH: flushPending set.
- ACCEPT: recordTaken = recordValid.
  - On take, the record is written at buffer positions fillCount..fillCount+len-1.
  - fillCount += len.
  - Next state is DRAIN if the new fillCount>=W, else ACCEPT.
- DRAIN: recordTaken=0 and dataOutValid=1. dataOut is buffer[W-1:0] and dataOutByteCount=W.
  - On valid&&ready, the buffer shifts down W bytes and fillCount -= W.
  - Return to ACCEPT (or FLUSH if pending) when fillCount<W.
- flush sampled high in any state sets flushPending. recordTaken is 0 while flushPending is set.
  - DRAIN continues unchanged until fillCount<W.
- FLUSH:
  - If fillCount>0, dataOutValid=1 and dataOutByteCount=fillCount. Lanes >= fillCount are FILL_BYTE, and dataOutLast=1.
  - On handshake, fillCount<=0, flushPending<=0, next state ACCEPT.
  - If fillCount==0, no word is emitted; flushPending clears next cycle.
- A full word emitted in DRAIN while flushPending is set has dataOutLast=1 only if fillCount==W (it empties the buffer).
- recordByteLength==0: the record is taken and nothing else changes.
- recordByteLength>MAX_RECORD_BYTES: treated as MAX_RECORD_BYTES.
- Append and drain never occur in the same cycle (ACCEPT implies no valid word).
- Arithmetic: fillCount is $clog2(41)=6 bits. Length is zero-extended before the add. No wrap is possible given the accept guard.

## Timing
- Reset values: recordTaken=0, dataOutValid=0, dataOutByteCount=0, dataOutLast=0, dataOut=all FILL_BYTE. fillCount=0, flushPending=0, state ACCEPT. Buffer contents are don't-care.
- recordTaken is combinational from registered state and recordValid; zero-cycle accept.
- First output word appears the cycle after the take that brings fillCount>=W.
- Sustained output is one word per cycle while in DRAIN and ready is high.
- dataOut, dataOutValid, dataOutByteCount and dataOutLast come from flops. They are stable while valid && !ready.
- Reset mid-operation drops all buffered bytes and any pending flush. The first post-reset cycle is ACCEPT.
- flush coincident with a take: the record is taken that cycle, and flushPending takes effect from the next cycle.

## Structure
- Shared package stream_pkg holds:
  - DATA_BUS_WIDTH_BYTES and MAX_UNCOMPRESSED_BYTES defaults.
  - VARIABLEFIELD_DELIMITER (8'h2c).
  - byte typedef.
  - packer state enum.
- Sub-module byte_append_shifter: combinational. Places a record at offset fillCount into a copy of the buffer, and provides the W-byte down-shift. The top level holds the state, counters and handshake.

## Test plan
- Two 5-byte records 01..05 then 11..15, ready=1: both taken with no word after the first. Word 01 02 03 04 05 11 12 13, count 8. fillCount=2 (14 15 retained).
- One 34-byte record 00..21 from empty: four words 00..07, 08..0f, 10..17, 18..1f in consecutive cycles. recordTaken=0 throughout. fillCount=2.
- fillCount=3 (AA BB CC), pulse flush: one word AA BB CC 00 00 00 00 00, count 3, last=1. Then a new record is taken immediately.
- dataOutReady low 5 cycles during DRAIN: dataOut and count held constant, no record taken. Word retires on the first ready cycle.
- Reset asserted mid-drain of a 34-byte record: the next cycle has valid=0 and fillCount=0. A following 8-byte record emits exactly one word.
- Zero-length record, then flush at fillCount=0: record taken, no word, last never asserted, flushPending clears within 1 cycle.
